// File: rtl/ukf_pkg.sv
// Shared widths and FSM state type for the UKF Cholesky result readback path.
package ukf_pkg;
  localparam int WORD_W   = 32;
  localparam int BEAT_W   = 128;
  localparam int LANES    = 4;
  localparam int IN_LANES = 5;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } ukf_state_e;
endpackage

// File: rtl/ukf_result_packer_if.sv
// Packed-beat readback handshake between the result packer and its consumer.
interface ukf_result_packer_if;
  import ukf_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [BEAT_W-1:0] out_data;
  logic [2:0]        out_fill;
  logic              out_last;

  modport master (output out_valid, out_data, out_fill, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_fill, out_last, output out_ready);
endinterface

// File: rtl/ukf_word_store.sv
// Circular word store: up to five contiguous writes and one quad read window per cycle.
module ukf_word_store
  import ukf_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        wr_cnt,
  input  logic [WORD_W-1:0] wr_data [IN_LANES],
  input  logic [2:0]        pop_cnt,
  output logic [WORD_W-1:0] rd_data [LANES],
  output logic [CW-1:0]     count
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;

  // Storage is not reset: pointers and count alone define what is valid.
  always_ff @(posedge clock) begin
    for (int i = 0; i < IN_LANES; i++) begin
      if (3'(i) < wr_cnt) mem_q[wr_ptr_q + AW'(i)] <= wr_data[i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(wr_cnt);
      rd_ptr_q <= rd_ptr_q + AW'(pop_cnt);
      count_q  <= count_q + CW'(wr_cnt) - CW'(pop_cnt);
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) rd_data[i] = mem_q[rd_ptr_q + AW'(i)];
  end

  assign count = count_q;

endmodule

// File: rtl/ukf_result_packer.sv
// Packs Cholesky result words into 128-bit beats; UKF_RESULT_STATS_EN adds words_emitted/overflow.
//   state | meaning
//   RUN   | accept qualified words, emit full beats
//   FLUSH | intake ignored, drain remainder, final beat tagged out_last
module ukf_result_packer
  import ukf_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int STALL_MARGIN = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        diag_available,
  input  logic [31:0] diag_out,
  input  logic [3:0]  lower_available,
  input  logic [31:0] lower1_out,
  input  logic [31:0] lower2_out,
  input  logic [31:0] lower3_out,
  input  logic [31:0] lower4_out,
  input  logic        finish,
  output logic        stop_pipeline,
  output logic        done,
`ifdef UKF_RESULT_STATS_EN
  output logic [15:0] words_emitted,
  output logic        overflow,
`endif
  ukf_result_packer_if.master beat
);

  localparam int CW = $clog2(DEPTH) + 1;

  ukf_state_e        state_q, state_d;
  logic              valid_q, last_q, last_sent_q, done_q;
  logic [BEAT_W-1:0] data_q;
  logic [2:0]        fill_q;

  logic [CW-1:0]     count, free_w;
  logic [WORD_W-1:0] rd_data [LANES];
  logic [WORD_W-1:0] in_word [IN_LANES];
  logic [WORD_W-1:0] wr_data [IN_LANES];
  logic [IN_LANES-1:0] in_vld;
  logic [2:0]        wr_cnt, pop_cnt;
  logic              loadable, load, ld_last, accept, accept_last;
  logic [BEAT_W-1:0] ld_data;
  logic [2:0]        ld_fill;
`ifdef UKF_RESULT_STATS_EN
  logic              drop;
  logic [15:0]       we_q;
  logic [16:0]       we_sum;
  logic              ovf_q;
`endif

  assign free_w        = CW'(DEPTH) - count;
  assign stop_pipeline = (free_w <= CW'(STALL_MARGIN)) || (state_q == FLUSH);

  assign in_word[0] = diag_out;
  assign in_word[1] = lower1_out;
  assign in_word[2] = lower2_out;
  assign in_word[3] = lower3_out;
  assign in_word[4] = lower4_out;
  assign in_vld     = {lower_available, diag_available} & {IN_LANES{state_q == RUN}};

  // Compact qualified words in lane order; once the store is full every later word drops.
  always_comb begin
    int n;
    n = 0;
    for (int k = 0; k < IN_LANES; k++) wr_data[k] = '0;
`ifdef UKF_RESULT_STATS_EN
    drop = 1'b0;
`endif
    for (int i = 0; i < IN_LANES; i++) begin
      if (in_vld[i]) begin
        if (n < int'(free_w)) begin
          wr_data[n] = in_word[i];
          n = n + 1;
        end else begin
`ifdef UKF_RESULT_STATS_EN
          drop = 1'b1;
`endif
        end
      end
    end
    wr_cnt = 3'(n);
  end

  ukf_word_store #(.DEPTH(DEPTH)) u_store (
    .clock   (clock),
    .reset   (reset),
    .wr_cnt  (wr_cnt),
    .wr_data (wr_data),
    .pop_cnt (pop_cnt),
    .rd_data (rd_data),
    .count   (count)
  );

  assign loadable    = !valid_q || beat.out_ready;
  assign accept      = valid_q && beat.out_ready;
  assign accept_last = accept && last_q;

  always_comb begin
    load    = 1'b0;
    pop_cnt = 3'd0;
    ld_fill = 3'd0;
    ld_last = 1'b0;
    ld_data = '0;
    if (loadable) begin
      if (count >= CW'(LANES)) begin
        load    = 1'b1;
        pop_cnt = 3'(LANES);
        ld_fill = 3'(LANES);
        ld_last = (state_q == FLUSH) && (count == CW'(LANES));
      end else if (state_q == FLUSH && count != '0) begin
        load    = 1'b1;
        pop_cnt = 3'(count);
        ld_fill = 3'(count);
        ld_last = 1'b1;
      end else if (state_q == FLUSH && !last_sent_q) begin
        load    = 1'b1;
        ld_last = 1'b1;
      end
    end
    for (int i = 0; i < LANES; i++) begin
      if (3'(i) < pop_cnt) ld_data[i*WORD_W +: WORD_W] = rd_data[i];
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == RUN && finish) state_d = FLUSH;
    else if (state_q == FLUSH && accept_last) state_d = RUN;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= RUN;
      valid_q     <= 1'b0;
      data_q      <= '0;
      fill_q      <= '0;
      last_q      <= 1'b0;
      last_sent_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= accept_last;
      if (load) begin
        valid_q <= 1'b1;
        data_q  <= ld_data;
        fill_q  <= ld_fill;
        last_q  <= ld_last;
        if (ld_last) last_sent_q <= 1'b1;
      end else if (accept) begin
        valid_q <= 1'b0;
      end
      if (accept_last) last_sent_q <= 1'b0;
    end
  end

`ifdef UKF_RESULT_STATS_EN
  assign we_sum = {1'b0, we_q} + 17'(fill_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      we_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (accept) we_q <= we_sum[16] ? 16'hFFFF : we_sum[15:0];
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign words_emitted = we_q;
  assign overflow      = ovf_q;
`endif

  assign beat.out_valid = valid_q;
  assign beat.out_data  = data_q;
  assign beat.out_fill  = fill_q;
  assign beat.out_last  = last_q;
  assign done           = done_q;

endmodule

// File: tb/tb_ukf_result_packer.sv
// Scoreboard bench for ukf_result_packer: stimulus queues expected beats, a monitor checks accepted beats.
module tb_ukf_result_packer;
  import ukf_pkg::*;

  typedef struct {
    logic [127:0] data;
    logic [2:0]   fill;
    logic         last;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        diag_available = 1'b0;
  logic [31:0] diag_out = '0;
  logic [3:0]  lower_available = '0;
  logic [31:0] lower1_out = '0, lower2_out = '0, lower3_out = '0, lower4_out = '0;
  logic        finish = 1'b0;
  logic        stop_pipeline, done;
`ifdef UKF_RESULT_STATS_EN
  logic [15:0] words_emitted;
  logic        overflow;
`endif

  ukf_result_packer_if bus ();

  ukf_result_packer #(.DEPTH(16), .STALL_MARGIN(5)) dut (
    .clock           (clock),
    .reset           (reset),
    .diag_available  (diag_available),
    .diag_out        (diag_out),
    .lower_available (lower_available),
    .lower1_out      (lower1_out),
    .lower2_out      (lower2_out),
    .lower3_out      (lower3_out),
    .lower4_out      (lower4_out),
    .finish          (finish),
    .stop_pipeline   (stop_pipeline),
    .done            (done),
`ifdef UKF_RESULT_STATS_EN
    .words_emitted   (words_emitted),
    .overflow        (overflow),
`endif
    .beat            (bus.master)
  );

  always #5 clock = ~clock;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_done = 0;

  function automatic logic [127:0] mk(input logic [31:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  function automatic exp_t e(input logic [127:0] d, input logic [2:0] f, input logic l);
    exp_t x;
    x.data = d; x.fill = f; x.last = l;
    return x;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every accepted beat must match the head of the expected queue.
  always @(negedge clock) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL beat_unexpected: got data=%h fill=%0d last=%0b", bus.out_data, bus.out_fill, bus.out_last);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        if (bus.out_data !== x.data || bus.out_fill !== x.fill || bus.out_last !== x.last) begin
          n_err++;
          $display("FAIL beat: got data=%h fill=%0d last=%0b expected data=%h fill=%0d last=%0b",
                   bus.out_data, bus.out_fill, bus.out_last, x.data, x.fill, x.last);
        end
      end
    end
    if (!reset && done) n_done++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic intake(input logic dv, input logic [31:0] d, input logic [3:0] lv,
                        input logic [31:0] l1, l2, l3, l4, input logic fin);
    diag_available = dv; diag_out = d; lower_available = lv;
    lower1_out = l1; lower2_out = l2; lower3_out = l3; lower4_out = l4;
    finish = fin;
    tick();
    diag_available = 1'b0; diag_out = '0; lower_available = '0;
    lower1_out = '0; lower2_out = '0; lower3_out = '0; lower4_out = '0;
    finish = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < max_cyc) begin tick(); c++; end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_timeout: %0d beats outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_done(input string name, input int base);
    int c;
    c = 0;
    while (n_done == base && c < 12) begin tick(); c++; end
    repeat (4) tick();
    check({name, "_done_pulses"}, 128'(n_done - base), 128'd1);
  endtask

  initial begin
    int base, n_drv;
    logic [127:0] beat_a;
    bus.out_ready = 1'b0;

    // Reset values
    do_reset();
    check("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("rst_out_data", bus.out_data, 128'd0);
    check("rst_out_fill", 128'(bus.out_fill), 128'd0);
    check("rst_out_last", 128'(bus.out_last), 128'd0);
    check("rst_stop", 128'(stop_pipeline), 128'd0);
    check("rst_done", 128'(done), 128'd0);

    // Four-word intake: beat visible two cycles later
    bus.out_ready = 1'b1;
    exp_q.push_back(e(mk(32'h11, 32'h21, 32'h22, 32'h23), 3'd4, 1'b0));
    intake(1'b1, 32'h11, 4'b0111, 32'h21, 32'h22, 32'h23, 32'h0, 1'b0);
    check("lat_c1_valid", 128'(bus.out_valid), 128'd0);
    tick();
    check("lat_c2_valid", 128'(bus.out_valid), 128'd1);
    wait_drain("t1", 10);

    // Six words then finish: full beat plus 2-word tail tagged last
    do_reset();
    bus.out_ready = 1'b1;
    base = n_done;
    exp_q.push_back(e(mk(32'h01, 32'h02, 32'h03, 32'h04), 3'd4, 1'b0));
    exp_q.push_back(e(mk(32'h05, 32'hAA, 32'h0, 32'h0), 3'd2, 1'b1));
    intake(1'b1, 32'h01, 4'b1111, 32'h02, 32'h03, 32'h04, 32'h05, 1'b0);
    intake(1'b1, 32'hAA, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    check("t2_stop_in_flush", 128'(stop_pipeline), 128'd1);
    wait_drain("t2", 10);
    wait_done("t2", base);
    check("t2_stop_after", 128'(stop_pipeline), 128'd0);

    // Backpressure: stall rises at count 11, held beat stays stable
    do_reset();
    for (int b = 0; b < 3; b++)
      exp_q.push_back(e(mk(32'h100 + 4*b, 32'h101 + 4*b, 32'h102 + 4*b, 32'h103 + 4*b), 3'd4, 1'b0));
    exp_q.push_back(e(mk(32'h10C, 32'h10D, 32'h10E, 32'h0), 3'd3, 1'b1));
    beat_a = mk(32'h100, 32'h101, 32'h102, 32'h103);
    n_drv = 0;
    while (!stop_pipeline && n_drv < 8) begin
      intake(1'b1, 32'h100 + 5*n_drv, 4'b1111, 32'h101 + 5*n_drv, 32'h102 + 5*n_drv,
             32'h103 + 5*n_drv, 32'h104 + 5*n_drv, 1'b0);
      n_drv++;
    end
    check("t3_cycles_before_stall", 128'(n_drv), 128'd3);
    check("t3_stop", 128'(stop_pipeline), 128'd1);
    repeat (3) tick();
    check("t3_held_valid", 128'(bus.out_valid), 128'd1);
    check("t3_held_data", bus.out_data, beat_a);
    base = n_done;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10 && exp_q.size() > 1; c++) tick();
    intake(1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    wait_drain("t3", 10);
    wait_done("t3", base);

    // Overflow: 5 words into 2 free slots keeps the first 2
    do_reset();
    intake(1'b1, 32'h200, 4'b1111, 32'h201, 32'h202, 32'h203, 32'h204, 1'b0);
    intake(1'b1, 32'h205, 4'b1111, 32'h206, 32'h207, 32'h208, 32'h209, 1'b0);
    intake(1'b1, 32'h20A, 4'b1111, 32'h20B, 32'h20C, 32'h20D, 32'h20E, 1'b0);
    intake(1'b1, 32'h20F, 4'b0011, 32'h210, 32'h211, 32'h0, 32'h0, 1'b0);
`ifdef UKF_RESULT_STATS_EN
    check("t4_overflow_before", 128'(overflow), 128'd0);
`endif
    intake(1'b1, 32'h212, 4'b1111, 32'h213, 32'h214, 32'h215, 32'h216, 1'b0);
`ifdef UKF_RESULT_STATS_EN
    check("t4_overflow_after", 128'(overflow), 128'd1);
`endif
    for (int b = 0; b < 5; b++)
      exp_q.push_back(e(mk(32'h200 + 4*b, 32'h201 + 4*b, 32'h202 + 4*b, 32'h203 + 4*b), 3'd4, 1'b0));
    exp_q.push_back(e(128'd0, 3'd0, 1'b1));
    bus.out_ready = 1'b1;
    for (int c = 0; c < 12 && exp_q.size() > 1; c++) tick();
    tick();
    base = n_done;
    intake(1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    wait_drain("t4", 10);
    wait_done("t4", base);
`ifdef UKF_RESULT_STATS_EN
    check("t4_words_emitted", 128'(words_emitted), 128'd20);
`endif

    // Empty finish with a second finish during FLUSH: exactly one zero beat
    do_reset();
    base = n_done;
    exp_q.push_back(e(128'd0, 3'd0, 1'b1));
    intake(1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    tick();
    intake(1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    tick();
    check("t5_zero_beat_held", 128'(bus.out_valid), 128'd1);
    bus.out_ready = 1'b1;
    wait_drain("t5", 10);
    wait_done("t5", base);
    check("t5_stop_after", 128'(stop_pipeline), 128'd0);

    // Reset while a beat is pending discards everything
    do_reset();
    intake(1'b1, 32'h400, 4'b1111, 32'h401, 32'h402, 32'h403, 32'h404, 1'b0);
    intake(1'b1, 32'h405, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    check("t6_valid_before_reset", 128'(bus.out_valid), 128'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_valid_after_reset", 128'(bus.out_valid), 128'd0);
    check("t6_data_after_reset", bus.out_data, 128'd0);
    bus.out_ready = 1'b1;
    exp_q.push_back(e(mk(32'h301, 32'h302, 32'h303, 32'h304), 3'd4, 1'b0));
    intake(1'b1, 32'h301, 4'b0111, 32'h302, 32'h303, 32'h304, 32'h0, 1'b0);
    wait_drain("t6", 10);
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ukf_result_packer.md
# ukf_result_packer

Downstream stage of the UKF Cholesky core: collects the 32-bit `diag_out` and `lower1_out`..`lower4_out` results it emits, buffers them in a word-granular circular store, and packs them four at a time into 128-bit beats for the readback path. Backpressure reaches the core through `stop_pipeline`, and `finish` triggers a flush of any partial beat tagged as last. Runs entirely in the fast domain.

## Interface
- `DEPTH`, 16: word store depth in 32-bit words; power of two, ≥8.
- `STALL_MARGIN`, 5: free-slot threshold at or below which `stop_pipeline` asserts; ≥5.
- `clock` in 1: single clock (the core's fast clock); all logic on its rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `diag_available` in 1: `diag_out` valid this cycle.
- `diag_out` in 32: diagonal result word.
- `lower_available` in 4: bit i-1 qualifies `lower{i}_out`.
- `lower1_out`..`lower4_out` in 32 each: lower-triangle lane results.
- `finish` in 1: single-cycle end-of-matrix pulse from the core.
- `stop_pipeline` out 1: stall request to the core.
- `out_valid` out 1: beat valid.
- `out_ready` in 1: consumer accepts the beat when high with `out_valid`.
- `out_data` out 128: packed beat; the oldest word is in [31:0].
- `out_fill` out 3: number of valid words in the beat (0–4).
- `out_last` out 1: final beat of the matrix.
- `done` out 1: one-cycle pulse after the last beat is accepted.

## Operation
- Intake per cycle, in order: `diag_out`, then `lower1_out`..`lower4_out`, writing only the qualified words. Up to 5 writes per cycle, contiguous from the write pointer, with pointers wrapping modulo `DEPTH`.
- `count` = stored words. `free` = `DEPTH` − `count`.
- `stop_pipeline` = (`free` ≤ `STALL_MARGIN`) OR (state = FLUSH). The signal is combinational from registered state.
- Overflow: if a word arrives when no slot is free, that word and every later word in the same cycle are dropped. Already-stored data is never overwritten.
- Output register load: when (`out_valid`=0 OR `out_ready`=1) and `count` ≥ 4, pop 4 words with `out_fill`=4.
- States:
  - RUN: normal intake.
  - FLUSH: intake is ignored and `stop_pipeline`=1.
  - Transitions:
    - RUN→FLUSH when `finish` is sampled. Words presented in the same cycle as `finish` are stored first.
    - FLUSH→RUN when the last beat is accepted, with `done` pulsing in that cycle.
- In FLUSH with 0 < `count` < 4 and the output register loadable: pop the remaining words, zero-pad the upper lanes, set `out_fill`=`count`, and set `out_last`=1.
- In FLUSH, a full beat that leaves `count`=0 carries `out_last`=1.
- In FLUSH with `count`=0 and no beat pending: emit one zero beat with `out_fill`=0 and `out_last`=1.
- Values held on `out_data`, `out_fill` and `out_last` stay stable while `out_valid`=1 and `out_ready`=0.
- `finish` arriving while already in FLUSH is ignored.

## Timing
- Reset values: `stop_pipeline`=0, `out_valid`=0, `out_data`=0, `out_fill`=0, `out_last`=0, `done`=0, `count`=0, pointers=0, state RUN.
- Latency: the 4th word presented in cycle c is sampled at the end of c. `out_valid` goes high in cycle c+2 if the output register is free.
- Throughput: 1 beat/cycle with `out_ready` held high.
- Simultaneous push and pop in one cycle: `count` += pushed − popped. Free space freed by the pop is not usable for that cycle's pushes.
- `stop_pipeline` reflects the state after the previous edge. The core may still deliver one cycle of data after assertion, which `STALL_MARGIN` ≥5 absorbs.
- `reset` asserted mid-beat or mid-flush: all outputs return to their reset values on the next edge and buffered data is discarded.

## Configuration
- `UKF_RESULT_STATS_EN` defined:
  - adds output `words_emitted` [15:0], counting valid words in accepted beats and saturating at 0xFFFF;
  - adds output `overflow` [0], a sticky flag set on any dropped word;
  - both are cleared only by `reset`.
- Undefined: neither port exists and drops are silent. The packing behaviour is identical in both builds.

## Structure
- Shared package `ukf_pkg`:
  - word width 32, beat width 128, lanes per beat 4, intake lanes 5;
  - state enum `{RUN, FLUSH}`.
- One natural sub-module: `ukf_word_store`, the multi-write (≤5) / quad-read circular register array with pointers and `count`. The top handles intake ordering, the FSM, and the output register.

## Test plan
- Reset, then intake in cycle 0: diag=0x11, lower valid=4'b0111 with 0x21/0x22/0x23, `out_ready`=1 → cycle 2: `out_data`={0x23,0x22,0x21,0x11}, `out_fill`=4, `out_last`=0.
- 6 words (diag + all 4 lanes, then diag=0xAA) followed by `finish` → one full beat, then a beat with `out_fill`=2, word1=0xAA, upper lanes 0, `out_last`=1, `done` pulses on acceptance.
- `out_ready`=0 with 5 words/cycle, `DEPTH`=16 → `stop_pipeline` rises once `count` ≥11; `out_data` is held stable.
- Push 5 words into 2 free slots → the first 2 are stored and 3 dropped; `overflow`=1 when `UKF_RESULT_STATS_EN` is defined.
- `finish` with an empty store → a single beat with `out_fill`=0 and `out_last`=1; `finish` during FLUSH → no second flush.
- `reset` while `out_valid`=1 → next cycle `out_valid`=0 and `count`=0; a subsequent 4-word intake emits a correct beat.
